usb_mem_responder: RTL and testbench

- Memory-side responder for the USB streaming word channel: serves the channel's usb_addr/usb_rd/usb_wr handshakes from a pipelined 32-bit memory port (SDRAM controller front end).
- Read path: address-tagged prefetch FIFO, so a sequential IN stream gets usb_rd_valid in the same cycle as usb_rd.
- Write path: a 2-entry posted write buffer.

---
 rtl/usb_mem_responder.sv | 165 ++++++++++++++++
 tb/tb_usb_mem_responder.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_mem_responder.sv
// Memory-side responder for the USB word channel: a tagged prefetch FIFO serves
// sequential reads, and a 2-entry posted buffer carries writes to a pipelined memory port.
module usb_mem_responder #(
  parameter int unsigned ADDR_W   = 29,
  parameter int unsigned PF_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] usb_addr,
  input  logic              usb_rd,
  output logic              usb_rd_valid,
  output logic [31:0]       usb_rd_data,
  input  logic              usb_wr,
  output logic              usb_wr_ready,
  input  logic [31:0]       usb_wr_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned WORD_W = ADDR_W - 2;
  localparam int unsigned PTR_W  = $clog2(PF_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned SUM_W  = CNT_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic [1:0]        state, state_nxt;
  logic [WORD_W-1:0] wb_word [2];
  logic [31:0]       wb_data [2];
  logic              wb_head;
  logic              wb_tail;
  logic [1:0]        wb_cnt;
  // One extra bit marks that the stream has run past the top of the address space.
  logic [WORD_W:0]   next_word;
  logic [WORD_W-1:0] resp_word;
  logic [CNT_W-1:0]  outst;
  logic [CNT_W-1:0]  pf_cnt;
  logic [PTR_W-1:0]  pf_rd_ptr, pf_wr_ptr;
  logic [WORD_W-1:0] pf_tag  [PF_DEPTH];
  logic [31:0]       pf_data [PF_DEPTH];

  logic [WORD_W-1:0] usb_word;
  logic              addr_lsb_unused;
  logic              wr_acc, wb_busy, wb_pop;
  logic              pf_empty, head_match, credit_ok;
  logic              rd_issue, rd_gnt, resp, pf_push, pf_pop, start;

  assign usb_word        = usb_addr[ADDR_W-1:2];
  assign addr_lsb_unused = ^usb_addr[1:0];

  assign usb_wr_ready = ~rst & (wb_cnt < 2'd2);
  assign wr_acc       = usb_wr & usb_wr_ready;
  assign wb_busy      = (wb_cnt != 2'd0);
  assign wb_tail      = wb_head ^ wb_cnt[0];
  assign wb_pop       = ~rst & wb_busy & mem_gnt;

  assign pf_empty   = (pf_cnt == '0);
  assign head_match = (pf_tag[pf_rd_ptr] == usb_word);
  assign credit_ok  = ({1'b0, outst} + {1'b0, pf_cnt}) < SUM_W'(PF_DEPTH);
  assign rd_issue   = ~rst & ~wb_busy & (state == S_FETCH) & credit_ok & ~next_word[WORD_W];
  assign rd_gnt     = rd_issue & mem_gnt;
  // Responses with nothing outstanding belong to traffic from before reset.
  assign resp       = mem_rvalid & (outst != '0);
  assign pf_push    = resp & (state == S_FETCH);
  assign pf_pop     = usb_rd_valid;
  assign start      = (state == S_IDLE) & (state_nxt == S_FETCH);

  assign usb_rd_valid = ~rst & usb_rd & ~pf_empty & head_match & (state == S_FETCH) & ~wr_acc;
  assign usb_rd_data  = (rst | pf_empty) ? 32'd0 : pf_data[pf_rd_ptr];

  // Memory command mux; buffered writes win over prefetch reads.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 32'd0;
    if (~rst & wb_busy) begin
      mem_req   = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = {wb_word[wb_head], 2'b00};
      mem_wdata = wb_data[wb_head];
    end else if (rd_issue) begin
      mem_req  = 1'b1;
      mem_addr = {next_word[WORD_W-1:0], 2'b00};
    end
  end

  // Stream control: any accepted write or address discontinuity flushes the prefetch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (wr_acc)      state_nxt = S_FLUSH;
        else if (usb_rd) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (wr_acc)
          state_nxt = S_FLUSH;
        else if (usb_rd & ~pf_empty & ~head_match)
          state_nxt = S_FLUSH;
        else if (usb_rd & pf_empty & (outst == '0) & (next_word != {1'b0, usb_word}))
          state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        if (outst == '0) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_head   <= 1'b0;
      wb_cnt    <= 2'd0;
      next_word <= '0;
      resp_word <= '0;
      outst     <= '0;
      pf_cnt    <= '0;
      pf_rd_ptr <= '0;
      pf_wr_ptr <= '0;
    end else begin
      if (wb_pop) wb_head <= ~wb_head;
      wb_cnt <= wb_cnt + 2'(wr_acc) - 2'(wb_pop);
      outst  <= outst + CNT_W'(rd_gnt) - CNT_W'(resp);
      if (start)       next_word <= {1'b0, usb_word};
      else if (rd_gnt) next_word <= next_word + (WORD_W+1)'(1);
      if (start)        resp_word <= usb_word;
      else if (pf_push) resp_word <= resp_word + WORD_W'(1);
      if (state == S_FLUSH) begin
        pf_cnt    <= '0;
        pf_rd_ptr <= '0;
        pf_wr_ptr <= '0;
      end else begin
        if (pf_push) pf_wr_ptr <= pf_wr_ptr + PTR_W'(1);
        if (pf_pop)  pf_rd_ptr <= pf_rd_ptr + PTR_W'(1);
        pf_cnt <= pf_cnt + CNT_W'(pf_push) - CNT_W'(pf_pop);
      end
    end
  end

  // Storage arrays need no reset; occupancy counters qualify every read.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      wb_word[wb_tail] <= usb_word;
      wb_data[wb_tail] <= usb_wr_data;
    end
    if (pf_push) begin
      pf_tag[pf_wr_ptr]  <= resp_word;
      pf_data[pf_wr_ptr] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_usb_mem_responder.sv
// Bench for usb_mem_responder: behavioural memory with fixed-latency in-order responses,
// directed scenarios followed by a randomized read/write mix checked against a word map.
module tb_usb_mem_responder;

  localparam int unsigned ADDR_W   = 29;
  localparam int unsigned PF_DEPTH = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] usb_addr = '0;
  logic              usb_rd = 1'b0;
  logic              usb_rd_valid;
  logic [31:0]       usb_rd_data;
  logic              usb_wr = 1'b0;
  logic              usb_wr_ready;
  logic [31:0]       usb_wr_data = 32'd0;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_gnt = 1'b0;
  logic              mem_rvalid = 1'b0;
  logic [31:0]       mem_rdata = 32'd0;

  usb_mem_responder #(.ADDR_W(ADDR_W), .PF_DEPTH(PF_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .usb_addr(usb_addr), .usb_rd(usb_rd), .usb_rd_valid(usb_rd_valid), .usb_rd_data(usb_rd_data),
    .usb_wr(usb_wr), .usb_wr_ready(usb_wr_ready), .usb_wr_data(usb_wr_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural memory: sparse word map with a hashed default for untouched words.
  logic [31:0] mem_m [int unsigned];

  function automatic logic [31:0] get_word(input logic [ADDR_W-1:0] a);
    int unsigned k;
    k = {3'b000, a[ADDR_W-1:2], 2'b00};
    if (mem_m.exists(k)) return mem_m[k];
    return (k * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  typedef struct { logic [31:0] data; int due; } rsp_t;
  typedef struct { logic [ADDR_W-1:0] addr; logic [31:0] data; } wr_t;

  rsp_t rq[$];
  wr_t  wq[$];
  int   cyc = 0;
  int   lat = 3;
  int   gnt_hold = 0;
  bit   gnt_force0 = 1'b0;
  bit   gnt_rand = 1'b0;
  int   inject_cycle = -1;
  int   bench_outst = 0;
  int   rd_grants = 0;
  int unsigned rd_floor = 0;
  bit   wrap_seen = 1'b0;

  // Memory controller model, sharing the DUT reset.
  always @(posedge clk) begin
    rsp_t r;
    wr_t  w;
    if (rst) begin
      rq.delete();
      bench_outst = 0;
      mem_rvalid <= 1'b0;
      mem_rdata  <= 32'd0;
    end else begin
      if (mem_rvalid && bench_outst > 0) bench_outst--;
      if (mem_req && mem_gnt) begin
        if (mem_we) begin
          if (wq.size() == 0) begin
            check("wr_unexpected", 64'(mem_addr), 64'hFFFF_FFFF);
          end else begin
            w = wq.pop_front();
            check("wr_addr_order", 64'(mem_addr), 64'(w.addr));
            check("wr_data", 64'(mem_wdata), 64'(w.data));
            mem_m[{3'b000, mem_addr}] = mem_wdata;
          end
        end else begin
          r.data = get_word(mem_addr);
          r.due  = cyc + lat;
          rq.push_back(r);
          bench_outst++;
          rd_grants++;
          if ({3'b000, mem_addr} < rd_floor) wrap_seen = 1'b1;
          check("outstanding_le_depth", 64'(bench_outst <= PF_DEPTH), 64'd1);
        end
      end
      if (inject_cycle == cyc + 1) begin
        mem_rvalid <= 1'b1;
        mem_rdata  <= 32'hBAD0_BAD0;
      end else if (rq.size() != 0 && rq[0].due == cyc + 1) begin
        r = rq.pop_front();
        mem_rvalid <= 1'b1;
        mem_rdata  <= r.data;
      end else begin
        mem_rvalid <= 1'b0;
      end
    end
    if (gnt_hold > 0) begin
      gnt_hold--;
      mem_gnt <= 1'b0;
    end else if (gnt_force0) mem_gnt <= 1'b0;
    else if (gnt_rand)       mem_gnt <= 1'($urandom % 2);
    else                     mem_gnt <= 1'b1;
    cyc++;
  end

  task automatic idle(input int n);
    usb_rd = 1'b0;
    usb_wr = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    usb_rd = 1'b0;
    usb_wr = 1'b0;
    rst = 1'b1;
    wq.delete();
    gnt_force0 = 1'b0;
    gnt_rand = 1'b0;
    gnt_hold = 0;
    inject_cycle = -1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
  endtask

  // Hold a read request until it is served; leaves usb_rd high for back-to-back streaming.
  task automatic read_word(input logic [ADDR_W-1:0] a, input int budget,
                           output int waited, output logic [31:0] d);
    bit got;
    got = 1'b0;
    waited = 0;
    d = 32'd0;
    usb_rd = 1'b1;
    usb_wr = 1'b0;
    usb_addr = a;
    while (!got && waited < budget) begin
      @(negedge clk);
      if (usb_rd_valid) begin
        got = 1'b1;
        d = usb_rd_data;
        check($sformatf("rd_data@%0h", a), 64'(d), 64'(get_word(a)));
      end else waited++;
      @(posedge clk); #1;
    end
    check($sformatf("rd_served@%0h", a), 64'(got), 64'd1);
  endtask

  task automatic write_word(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                            input int budget, output int waited);
    bit got;
    wr_t w;
    got = 1'b0;
    waited = 0;
    usb_rd = 1'b0;
    usb_wr = 1'b1;
    usb_addr = a;
    usb_wr_data = d;
    while (!got && waited < budget) begin
      @(negedge clk);
      if (usb_wr_ready) begin
        got = 1'b1;
        w.addr = {a[ADDR_W-1:2], 2'b00};
        w.data = d;
        wq.push_back(w);
      end else waited++;
      @(posedge clk); #1;
    end
    usb_wr = 1'b0;
    check($sformatf("wr_accepted@%0h", a), 64'(got), 64'd1);
  endtask

  initial begin
    int w;
    int wt [4];
    logic [31:0] d;
    logic [ADDR_W-1:0] cur;
    int r;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rd_valid", 64'(usb_rd_valid), 64'd0);
    check("rst_rd_data", 64'(usb_rd_data), 64'd0);
    check("rst_wr_ready", 64'(usb_wr_ready), 64'd0);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1 check("wr_ready_after_rst", 64'(usb_wr_ready), 64'd1);

    // Sequential stream, latency 3, grant always
    do_reset();
    lat = 3;
    for (int i = 0; i < 16; i++) begin
      read_word(29'h100 + 29'(4 * i), 50, w, d);
      if (i == 0) check("stream_first_latency", 64'(w), 64'd5);
      else        check($sformatf("stream_back_to_back_%0d", i), 64'(w), 64'd0);
    end
    idle(10);

    // Jump mid-stream
    do_reset();
    for (int i = 0; i < 9; i++) read_word(29'h100 + 29'(4 * i), 50, w, d);
    read_word(29'h8000, 80, w, d);
    check("jump_waits_for_flush", 64'(w >= 6), 64'd1);
    read_word(29'h8004, 50, w, d);
    check("jump_continues", 64'(w), 64'd0);
    idle(10);

    // Write backpressure
    do_reset();
    gnt_hold = 5;
    for (int i = 0; i < 4; i++) write_word(29'h40 + 29'(4 * i), 32'hC0DE_0000 + 32'(i), 40, wt[i]);
    check("bp_accept0", 64'(wt[0]), 64'd0);
    check("bp_accept1", 64'(wt[1]), 64'd0);
    check("bp_ready_dropped", 64'(wt[2] > 0), 64'd1);
    idle(10);
    check("bp_all_writes_seen", 64'(wq.size()), 64'd0);

    // Coherence: write into a prefetched region
    do_reset();
    read_word(29'h200, 50, w, d);
    idle(12);
    write_word(29'h208, 32'hDEAD_BEEF, 40, w);
    idle(3);
    for (int i = 0; i < 8; i++) begin
      read_word(29'h200 + 29'(4 * i), 80, w, d);
      if (i == 2) check("coherence_208", 64'(d), 64'hDEAD_BEEF);
    end
    idle(10);

    // Top of address space
    do_reset();
    rd_grants = 0;
    rd_floor = 32'h1FFF_FFF0;
    wrap_seen = 1'b0;
    for (int i = 0; i < 4; i++) read_word(29'h1FFF_FFF0 + 29'(4 * i), 50, w, d);
    idle(12);
    check("top_read_count", 64'(rd_grants), 64'd4);
    check("top_no_wrap", 64'(wrap_seen), 64'd0);
    rd_floor = 0;

    // Reset with reads outstanding and writes buffered
    do_reset();
    lat = 20;
    usb_rd = 1'b1;
    usb_addr = 29'h300;
    for (int i = 0; i < 40 && bench_outst < 5; i++) begin @(posedge clk); #1; end
    check("mid_outst_reached", 64'(bench_outst >= 5), 64'd1);
    gnt_force0 = 1'b1;
    write_word(29'h500, 32'h1111_1111, 10, w);
    write_word(29'h504, 32'h2222_2222, 10, w);
    @(negedge clk);
    check("mid_wb_pending", 64'({mem_req, mem_we}), 64'd3);
    @(posedge clk); #1;
    wq.delete();
    gnt_force0 = 1'b0;
    lat = 3;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_rd_valid", 64'(usb_rd_valid), 64'd0);
    check("mid_rst_rd_data", 64'(usb_rd_data), 64'd0);
    check("mid_rst_wr_ready", 64'(usb_wr_ready), 64'd0);
    check("mid_rst_mem_req", 64'(mem_req), 64'd0);
    check("mid_rst_mem_we", 64'(mem_we), 64'd0);
    check("mid_rst_mem_addr", 64'(mem_addr), 64'd0);
    check("mid_rst_mem_wdata", 64'(mem_wdata), 64'd0);
    usb_rd = 1'b0;
    rst = 1'b0;
    #1 check("mid_wr_ready_release", 64'(usb_wr_ready), 64'd1);
    @(posedge clk); #1;
    inject_cycle = cyc + 1;
    read_word(29'h400, 50, w, d);
    check("late_rvalid_ignored_latency", 64'(w), 64'd5);
    idle(10);

    // Randomized mix, random grant, random fixed latency
    do_reset();
    lat = int'($urandom_range(1, 7));
    gnt_rand = 1'b1;
    cur = 29'h1000;
    for (int n = 0; n < 150; n++) begin
      r = int'($urandom % 100);
      if (r < 65) begin
        read_word(cur, 300, w, d);
        cur = (cur >= 29'h10FC) ? 29'h1000 : cur + 29'd4;
      end else if (r < 78) begin
        cur = 29'h1000 + 29'(4 * $urandom_range(0, 63));
        read_word(cur, 300, w, d);
        cur = (cur >= 29'h10FC) ? 29'h1000 : cur + 29'd4;
      end else if (r < 92) begin
        write_word(29'h1000 + 29'(4 * $urandom_range(0, 63)), $urandom, 300, w);
      end else begin
        idle(int'($urandom_range(1, 3)));
      end
    end
    idle(40);
    check("rand_all_writes_seen", 64'(wq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
